// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared opcodes, func3 codes, FSM states and BHT helpers for branch resolution
package branch_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        REDIR = 2'd2
    } br_state_t;

    // Weakly not-taken so a fresh entry flips after a single taken outcome.
    localparam logic [1:0] BHT_RST = 2'b01;

    function automatic logic [1:0] bht_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && ctr != 2'b11) begin
            nxt = ctr + 2'b01;
        end else if (!taken && ctr != 2'b00) begin
            nxt = ctr - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_bht.sv
// rtl/branch_bht.sv - 2-bit saturating branch history table with one lookup and one update port
module branch_bht
    import branch_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] lookup_idx,
    output logic             lookup_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [1:0] ctr [ENTRIES];

    // Lookup reads the pre-edge value, so a same-cycle update to the same index is not visible yet.
    assign lookup_taken = ctr[lookup_idx][1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= BHT_RST;
            end
        end else if (upd_en) begin
            ctr[upd_idx] <= bht_next(ctr[upd_idx], upd_taken);
        end
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - ID-stage branch resolve/redirect sequencer; BRANCH_PRED_EN adds a BHT predictor
module branch_resolve_ctrl
    import branch_pkg::*;
#(
    parameter int BHT_IDX_W = 6,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [6:0]       id_op,
    input  logic [2:0]       id_func3,
    input  logic [31:0]      id_pc,
    input  logic [31:0]      id_imm,
    input  logic             id_pred_taken,
    input  logic             rs1_ready,
    input  logic             rs2_ready,
    input  logic [31:0]      rs1_data,
    input  logic [31:0]      rs2_data,
    input  logic             cmp_take,
    input  logic             ex_flush,
    input  logic [31:0]      if_pc,
    output logic [31:0]      cmp_src1,
    output logic [31:0]      cmp_src2,
    output logic [6:0]       cmp_op,
    output logic [2:0]       cmp_func3,
    output logic             stall_id,
    output logic             flush_if_id,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             if_pred_taken,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    br_state_t state, state_nxt;
    logic      is_br;
    logic      ops_ready;
    logic      pred_taken;
    logic      mispred;
    logic      resolve;

    assign is_br     = id_valid && (id_op == OP_BRANCH);
    assign ops_ready = rs1_ready && rs2_ready;
    assign mispred   = cmp_take ^ pred_taken;

    always_comb begin
        cmp_src1  = '0;
        cmp_src2  = '0;
        cmp_op    = '0;
        cmp_func3 = '0;
        if (is_br) begin
            cmp_src1  = rs1_data;
            cmp_src2  = rs2_data;
            cmp_op    = id_op;
            cmp_func3 = id_func3;
        end
    end

`ifdef BRANCH_PRED_EN
    logic unused_if_pc_bits;

    branch_bht #(
        .IDX_W(BHT_IDX_W)
    ) u_bht (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_idx   (if_pc[BHT_IDX_W+1:2]),
        .lookup_taken (if_pred_taken),
        .upd_en       (resolve),
        .upd_idx      (id_pc[BHT_IDX_W+1:2]),
        .upd_taken    (cmp_take)
    );

    assign pred_taken        = id_pred_taken;
    assign unused_if_pc_bits = ^{if_pc[31:BHT_IDX_W+2], if_pc[1:0]};
`else
    localparam int unused_bht_idx_w = BHT_IDX_W;
    logic unused_pred_inputs;

    // Static not-taken: any prediction carried from IF is meaningless here.
    assign if_pred_taken      = 1'b0;
    assign pred_taken         = 1'b0;
    assign unused_pred_inputs = ^{if_pc, id_pred_taken};
`endif

    always_comb begin
        state_nxt      = state;
        stall_id       = 1'b0;
        flush_if_id    = 1'b0;
        redirect_valid = 1'b0;
        resolve        = 1'b0;
        unique case (state)
            IDLE: begin
                if (is_br) begin
                    if (ops_ready) begin
                        resolve = 1'b1;
                    end else begin
                        stall_id  = 1'b1;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!is_br) begin
                    state_nxt = IDLE;
                end else if (ops_ready) begin
                    resolve = 1'b1;
                end else begin
                    stall_id = 1'b1;
                end
            end
            REDIR: begin
                // Whatever sits in ID now is wrong-path and gets squashed, never resolved.
                redirect_valid = 1'b1;
                flush_if_id    = 1'b1;
                state_nxt      = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (resolve) begin
            state_nxt = mispred ? REDIR : IDLE;
        end

        // An older redirect or trap outranks anything this stage is doing.
        if (ex_flush) begin
            state_nxt      = IDLE;
            stall_id       = 1'b0;
            flush_if_id    = 1'b0;
            redirect_valid = 1'b0;
            resolve        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
            redirect_pc <= '0;
        end else begin
            state <= state_nxt;
            if (resolve) begin
                if (branch_cnt != CNT_MAX) begin
                    branch_cnt <= branch_cnt + CNT_ONE;
                end
                if (mispred) begin
                    if (mispred_cnt != CNT_MAX) begin
                        mispred_cnt <= mispred_cnt + CNT_ONE;
                    end
                    redirect_pc <= cmp_take ? (id_pc + id_imm) : (id_pc + 32'd4);
                end
            end
        end
    end

endmodule
